// File: rtl/fade_pkg.sv
// Shared state encodings and level limits for the day/night fade sequencer.
package fade_pkg;

  typedef logic [2:0] fade_state_t;

  localparam fade_state_t ST_IDLE       = 3'd0;
  localparam fade_state_t ST_RISE       = 3'd1;
  localparam fade_state_t ST_HOLD_DAY   = 3'd2;
  localparam fade_state_t ST_FALL       = 3'd3;
  localparam fade_state_t ST_HOLD_NIGHT = 3'd4;

  localparam logic [7:0] LEVEL_MAX = 8'd255;
  localparam logic [7:0] LEVEL_MIN = 8'd0;

  function automatic logic is_legal(input fade_state_t s);
    return s <= ST_HOLD_NIGHT;
  endfunction

endpackage

// File: rtl/fade_tick_prescaler.sv
// Step-period prescaler: ticks once every period+1 enabled clocks.
module fade_tick_prescaler #(
  parameter int PRESCALE_W = 20
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  en,
  input  logic                  clr,
  input  logic [PRESCALE_W-1:0] period,
  output logic                  tick
);

  logic [PRESCALE_W-1:0] r_cnt;

  // >= so a period lowered below the running count fires at once
  assign tick = en && (r_cnt >= period);

  always_ff @(posedge clk) begin
    if (!rst_n)   r_cnt <= '0;
    else if (clr) r_cnt <= '0;
    else if (en)  r_cnt <= tick ? '0 : r_cnt + PRESCALE_W'(1);
  end

endmodule

// File: rtl/fade_sequencer.sv
// Day/night fade sequencer: ramps an 8-bit level up, dwells, ramps down, dwells.
module fade_sequencer
  import fade_pkg::*;
#(
  parameter int PRESCALE_W = 20,
  parameter int HOLD_W     = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  run,
  input  logic                  restart,
  input  logic [PRESCALE_W-1:0] step_period,
  input  logic [HOLD_W-1:0]     hold_ticks,
  output logic [7:0]            level,
  output logic                  direction,
  output logic [2:0]            state,
  output logic                  step,
  output logic                  cycle_done
);

  fade_state_t       r_state, w_next_state;
  logic [7:0]        r_level, w_level_nxt;
  logic [HOLD_W-1:0] r_hold_cnt, w_hold_cnt_nxt;
  logic [HOLD_W-1:0] r_hold_lat, w_hold_lat_nxt;
  logic              r_dir, r_step, r_done;
  logic              w_dir_nxt, w_step_nxt, w_done_nxt;
  logic              w_tick, w_presc_en, w_presc_clr;

  assign w_presc_en  = run && (r_state != ST_IDLE) && is_legal(r_state);
  assign w_presc_clr = restart || (r_state == ST_IDLE);

  fade_tick_prescaler #(.PRESCALE_W(PRESCALE_W)) u_presc (
    .clk    (clk),
    .rst_n  (rst_n),
    .en     (w_presc_en),
    .clr    (w_presc_clr),
    .period (step_period),
    .tick   (w_tick)
  );

  // State register; illegal encodings recover even while frozen
  always_ff @(posedge clk) begin
    if (!rst_n)                r_state <= ST_IDLE;
    else if (restart)          r_state <= run ? ST_RISE : ST_IDLE;
    else if (run)              r_state <= w_next_state;
    else if (!is_legal(r_state)) r_state <= ST_IDLE;
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_IDLE:       w_next_state = ST_RISE;
      ST_RISE:       if (w_tick && r_level == LEVEL_MAX - 8'd1) w_next_state = ST_HOLD_DAY;
      ST_HOLD_DAY:   if (w_tick && r_hold_cnt == r_hold_lat)    w_next_state = ST_FALL;
      ST_FALL:       if (w_tick && r_level == LEVEL_MIN + 8'd1) w_next_state = ST_HOLD_NIGHT;
      ST_HOLD_NIGHT: if (w_tick && r_hold_cnt == r_hold_lat)    w_next_state = ST_RISE;
      default:       w_next_state = ST_IDLE;
    endcase
  end

  always_comb begin
    w_level_nxt    = r_level;
    w_hold_cnt_nxt = r_hold_cnt;
    w_hold_lat_nxt = r_hold_lat;
    w_step_nxt     = 1'b0;
    w_done_nxt     = 1'b0;
    case (r_state)
      ST_RISE: if (w_tick && r_level != LEVEL_MAX) begin
        w_level_nxt = r_level + 8'd1;
        w_step_nxt  = 1'b1;
        if (r_level == LEVEL_MAX - 8'd1) begin
          w_hold_cnt_nxt = '0;
          w_hold_lat_nxt = hold_ticks;
        end
      end
      ST_FALL: if (w_tick && r_level != LEVEL_MIN) begin
        w_level_nxt = r_level - 8'd1;
        w_step_nxt  = 1'b1;
        if (r_level == LEVEL_MIN + 8'd1) begin
          w_hold_cnt_nxt = '0;
          w_hold_lat_nxt = hold_ticks;
          w_done_nxt     = 1'b1;
        end
      end
      ST_HOLD_DAY, ST_HOLD_NIGHT: if (w_tick)
        w_hold_cnt_nxt = (r_hold_cnt == r_hold_lat) ? '0 : r_hold_cnt + HOLD_W'(1);
      default: ;
    endcase
    w_dir_nxt = (w_next_state == ST_HOLD_DAY) || (w_next_state == ST_FALL);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_level    <= LEVEL_MIN;
      r_hold_cnt <= '0;
      r_hold_lat <= '0;
      r_dir      <= 1'b0;
      r_step     <= 1'b0;
      r_done     <= 1'b0;
    end else if (restart) begin
      r_level    <= LEVEL_MIN;
      r_hold_cnt <= '0;
      r_dir      <= 1'b0;
      r_step     <= 1'b0;
      r_done     <= 1'b0;
    end else if (run) begin
      r_level    <= w_level_nxt;
      r_hold_cnt <= w_hold_cnt_nxt;
      r_hold_lat <= w_hold_lat_nxt;
      r_dir      <= w_dir_nxt;
      r_step     <= w_step_nxt;
      r_done     <= w_done_nxt;
    end else begin
      r_step     <= 1'b0;
      r_done     <= 1'b0;
    end
  end

  assign level      = r_level;
  assign direction  = r_dir;
  assign state      = r_state;
  assign step       = r_step;
  assign cycle_done = r_done;

endmodule

// File: doc/fade_sequencer.md
# fade_sequencer

Day/night fade sequencer. Owns the 8-bit fade level and steps it through a rise, day dwell, fall, night dwell cycle. Step rate and dwell length are programmable at run time. It has run/freeze and restart controls for the display top level. It sits between the top-level control inputs and the colour/PWM blend logic, which consumes `level` and `direction`.

## Interface
Parameters:
- `PRESCALE_W`, 20, width of the step-period prescaler.
- `HOLD_W`, 8, width of the dwell counter.

Ports:
- `clk` in 1: system clock. This is the block's only clock.
- `rst_n` in 1: reset, synchronous and active-low.
- `run` in 1: 1 = sequence advances; 0 = freeze all state.
- `restart` in 1: single-cycle pulse that restarts the sequence from night.
- `step_period` in PRESCALE_W: a tick occurs every `step_period`+1 clocks.
- `hold_ticks` in HOLD_W: dwell length is `hold_ticks`+1 ticks.
- `level` out 8: current fade level, 0..255.
- `direction` out 1: 1 in HOLD_DAY and FALL; 0 otherwise.
- `state` out 3: current FSM state.
- `step` out 1: one-cycle pulse on every clock where `level` changes.
- `cycle_done` out 1: one-cycle pulse on entry to HOLD_NIGHT.

## Operation
- States: IDLE=0, RISE=1, HOLD_DAY=2, FALL=3, HOLD_NIGHT=4. Encodings 5..7 are illegal and recover to IDLE on the next clock.
- Reset (`rst_n`=0 at clk edge) has highest priority. Resulting values:
  - `state`=IDLE, `level`=0, `direction`=0, `step`=0, `cycle_done`=0.
  - Prescaler=0, hold counter=0, latched hold=0.
- `restart`=1 is the second priority:
  - `level`<=0 and prescaler, hold counter <=0.
  - `state`<=RISE if `run`=1, otherwise IDLE.
  - No `step` and no `cycle_done` pulse.
- `run`=0 freezes every register, including the prescaler phase. `step` and `cycle_done` are 0 while frozen. `restart` and `rst_n` are still honoured.
- IDLE: when `run`=1, go to RISE on the next edge with prescaler=0.
- Tick: internal, combinational. Asserted when `run`=1, state is not IDLE, and prescaler >= `step_period`.
  - On a tick, the prescaler wraps to 0; otherwise it increments.
  - Using >= means a `step_period` lowered below the current count ticks immediately.
- RISE:
  - Each tick: `level`+1, `step`=1.
  - The tick that makes `level`=255 also moves to HOLD_DAY. On that edge, clear the hold counter and latch `hold_ticks`.
- HOLD_DAY: each tick increments the hold counter. On the tick where counter == latched value, go to FALL. Changes to `hold_ticks` mid-dwell are ignored.
- FALL: mirror of RISE. Each tick: `level`-1, `step`=1. The tick that makes `level`=0 moves to HOLD_NIGHT, latches `hold_ticks`, and pulses `cycle_done`.
- HOLD_NIGHT: dwell as HOLD_DAY, then go to RISE.
- `level` never wraps: it is clamped to 0..255 by construction.

## Timing
- All outputs are registered.
- `level`, `step`, `state` and `direction` update on the same edge as the tick that causes them.
- With `step_period`=N:
  - First increment occurs N+1 clocks after RISE entry.
  - A full ramp takes 255·(N+1) clocks.
  - A dwell takes (`hold_ticks`+1)·(N+1) clocks.
- `cycle_done` is coincident with the edge where `level` reaches 0.
- `restart` takes effect on the next edge. `level` reads 0 one clock after the pulse.
- Simultaneous `run`=0 and `restart`=1: restart applies, and `state` becomes IDLE.

## Structure
- Package `fade_pkg`:
  - State localparams (IDLE..HOLD_NIGHT).
  - `LEVEL_MAX`=8'd255 and `LEVEL_MIN`=8'd0.
- Sub-module `fade_tick_prescaler`: PRESCALE_W counter with enable and clear, `period` input, `tick` output.
- The FSM, level register and dwell counter live in `fade_sequencer`.

## Test plan
- Reset check:
  - Stimulus: `rst_n`=0 for 2 clocks with `run`=1.
  - Expect `level`=0, `state`=IDLE, `step`=0 during reset, and `state`=RISE one clock after release.
- Full cycle:
  - Stimulus: `step_period`=0, `hold_ticks`=0.
  - Expect `level`=255 and HOLD_DAY 255 clocks after RISE entry, then FALL 1 clock later.
  - Expect `level`=0 plus a single `cycle_done` 255 clocks later, then RISE 1 clock later.
- Step spacing:
  - Stimulus: `step_period`=3, `hold_ticks`=2.
  - Expect `step` pulses exactly 4 clocks apart, and a HOLD_DAY dwell of 12 clocks with `direction`=1.
- Freeze:
  - Stimulus: `run`=0 for 50 clocks at `level`=100 in RISE with prescaler=2 of period 5.
  - Expect `level` held at 100 and no `step`. After resume, the next step comes 4 clocks later.
- Restart:
  - Stimulus: `restart` pulse in HOLD_DAY.
  - Expect `level`=0, `state`=RISE, `direction`=0 the next clock, and no `cycle_done`.
- Period shrink:
  - Stimulus: `step_period` changes 1000→2 while the prescaler is at 500.
  - Expect a tick and `step` on the next edge, then steps every 3 clocks.
  - Also change `hold_ticks` mid-dwell; the dwell length must stay unchanged.
